// File: rtl/usb_pkg.sv
// Shared constants and types for the USB transmit packet builder: PID bytes,
// request encoding, FSM states, CRC-16/USB parameters and maximum payload.
package usb_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'h80;
    localparam logic [7:0] PID_DATA0  = 8'hC3;
    localparam logic [7:0] PID_DATA1  = 8'h4B;
    localparam logic [7:0] PID_ACK    = 8'hD2;
    localparam logic [7:0] PID_NAK    = 8'h5A;
    localparam logic [7:0] PID_STALL  = 8'h1E;

    localparam logic [15:0] CRC_POLY      = 16'h8005;
    // Bit-reversed form of CRC_POLY, used by the LSB-first shift register
    localparam logic [15:0] CRC_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_XOROUT    = 16'hFFFF;

    localparam logic [6:0] MAX_PKT_BYTES = 7'd64;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_pkt_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_PID    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC_LO = 3'd4,
        ST_CRC_HI = 3'd5,
        ST_EOP    = 3'd6
    } tx_state_e;

    function automatic logic [7:0] pid_byte(input logic [2:0] pkt);
        case (pkt)
            PKT_DATA0: pid_byte = PID_DATA0;
            PKT_DATA1: pid_byte = PID_DATA1;
            PKT_ACK:   pid_byte = PID_ACK;
            PKT_NAK:   pid_byte = PID_NAK;
            PKT_STALL: pid_byte = PID_STALL;
            default:   pid_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide CRC-16/USB accumulator (reflected, LSB first). Holds the raw
// running remainder; the caller applies the final XOR.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic [15:0] w_stage [0:8];

    assign w_stage[0] = r_crc ^ {8'h00, data};

    // One shift/conditional-XOR stage per input bit
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign w_stage[gi + 1] = w_stage[gi][0]
                                   ? ((w_stage[gi] >> 1) ^ CRC_POLY_REFL)
                                   : (w_stage[gi] >> 1);
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc <= CRC_INIT;
        end else if (clear) begin
            r_crc <= CRC_INIT;
        end else if (enable) begin
            r_crc <= w_stage[8];
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/usb_tx_packet_builder.sv
// USB transmit packet framer: SYNC/PID/DATA/CRC16/EOP byte sequencing from a FIFO.
// Define USB_TX_SYNC_EN to emit the 0x80 SYNC byte ahead of the PID.
module usb_tx_packet_builder
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready,
    output logic       tx_eop,
    output logic       tx_busy,
    output logic       tx_error
);

    tx_state_e   r_state;
    logic [7:0]  r_pid;
    logic        r_is_data;
    logic [6:0]  r_count;
    logic [7:0]  r_tx_byte;
    logic        r_tx_valid;
    logic        r_eop;
    logic        r_error;

    logic        w_req_valid;
    logic        w_req_data;
    logic        w_occ_nz;
    logic        w_xfer;
    logic        w_crc_clear;
    logic        w_pop;
    logic [15:0] w_crc;
    logic [15:0] w_crc_out;
    logic [7:0]  w_tx_byte;
    logic        w_tx_valid;

    assign w_req_valid = (tx_packet >= PKT_DATA0) && (tx_packet <= PKT_STALL);
    assign w_req_data  = (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
    assign w_occ_nz    = (buffer_occupancy != 7'd0);
    assign w_crc_out   = w_crc ^ CRC_XOROUT;
    assign w_crc_clear = (r_state == ST_IDLE) && w_req_valid;

    // DATA streams FIFO bytes straight through; CRC bytes come from the live remainder
    always_comb begin
        w_tx_byte  = r_tx_byte;
        w_tx_valid = r_tx_valid;
        case (r_state)
            ST_DATA: begin
                w_tx_valid = w_occ_nz;
                w_tx_byte  = w_occ_nz ? tx_packet_data : 8'h00;
            end
            ST_CRC_LO: w_tx_byte = w_crc_out[7:0];
            ST_CRC_HI: w_tx_byte = w_crc_out[15:8];
            default: ;
        endcase
    end

    assign w_xfer = w_tx_valid && tx_byte_ready;
    assign w_pop  = (r_state == ST_DATA) && w_xfer;

    usb_crc16 u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (w_crc_clear),
        .enable (w_pop),
        .data   (tx_packet_data),
        .crc    (w_crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_pid      <= 8'h00;
            r_is_data  <= 1'b0;
            r_count    <= 7'd0;
            r_tx_byte  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_eop      <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_eop   <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        if (w_req_data && (buffer_occupancy > MAX_PKT_BYTES)) begin
                            r_error <= 1'b1;
                        end else begin
                            r_pid      <= pid_byte(tx_packet);
                            r_is_data  <= w_req_data;
                            r_count    <= w_req_data ? buffer_occupancy : 7'd0;
                            r_tx_valid <= 1'b1;
`ifdef USB_TX_SYNC_EN
                            r_state    <= ST_SYNC;
                            r_tx_byte  <= SYNC_BYTE;
`else
                            r_state    <= ST_PID;
                            r_tx_byte  <= pid_byte(tx_packet);
`endif
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_xfer) begin
                        r_state   <= ST_PID;
                        r_tx_byte <= r_pid;
                    end
                end
                ST_PID: begin
                    if (w_xfer) begin
                        r_tx_byte <= 8'h00;
                        if (!r_is_data) begin
                            r_state    <= ST_EOP;
                            r_tx_valid <= 1'b0;
                            r_eop      <= 1'b1;
                        end else if (r_count != 7'd0) begin
                            r_state    <= ST_DATA;
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_state    <= ST_CRC_LO;
                            r_tx_valid <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!w_occ_nz) begin
                        // FIFO ran dry before the promised byte count was sent
                        r_state    <= ST_IDLE;
                        r_count    <= 7'd0;
                        r_tx_valid <= 1'b0;
                        r_error    <= 1'b1;
                    end else if (w_xfer) begin
                        r_count <= r_count - 7'd1;
                        if (r_count == 7'd1) begin
                            r_state    <= ST_CRC_LO;
                            r_tx_valid <= 1'b1;
                        end
                    end
                end
                ST_CRC_LO: begin
                    if (w_xfer) begin
                        r_state <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (w_xfer) begin
                        r_state    <= ST_EOP;
                        r_tx_valid <= 1'b0;
                        r_eop      <= 1'b1;
                    end
                end
                ST_EOP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tx_byte            = w_tx_byte;
    assign tx_byte_valid      = w_tx_valid;
    assign get_tx_packet_data = w_pop;
    assign tx_eop             = r_eop;
    assign tx_error           = r_error;
    assign tx_busy            = (r_state != ST_IDLE);

endmodule
